// File: rtl/nonce_dispatch_pkg.sv
// Shared types and widths for the nonce dispatcher and its result buffer.

package nonce_dispatch_pkg;

  localparam int unsigned NONCE_W = 32;
  localparam int unsigned ADDR_W  = 16;
  localparam int unsigned WORD_W  = 32;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DISPATCH = 2'd1,
    ST_WAIT     = 2'd2,
    ST_WRITE    = 2'd3
  } dispatch_state_t;

  // Index width for a buffer of n entries; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/nonce_result_buf.sv
// Nonce-indexed H0 result storage: one write port per core, one read port with
// write-first forwarding so a result captured this cycle is readable at once.

module nonce_result_buf
  import nonce_dispatch_pkg::*;
#(
  parameter int unsigned NUM_NONCES = 16,
  parameter int unsigned NUM_PORTS  = 4,
  parameter int unsigned IDX_W      = 4
) (
  input  logic                                clk,
  input  logic [NUM_PORTS-1:0]                wr_en_i,
  input  logic [NUM_PORTS-1:0][IDX_W-1:0]     wr_idx_i,
  input  logic [NUM_PORTS-1:0][WORD_W-1:0]    wr_data_i,
  input  logic [IDX_W-1:0]                    rd_idx_i,
  output logic [WORD_W-1:0]                   rd_data_c_o
);

  logic [WORD_W-1:0] mem_q [NUM_NONCES];

  // Contents survive reset; every job overwrites every entry before reading it.
  always_ff @(posedge clk) begin
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      if (wr_en_i[p] && (32'(wr_idx_i[p]) < NUM_NONCES)) begin
        mem_q[wr_idx_i[p]] <= wr_data_i[p];
      end
    end
  end

  always_comb begin
    rd_data_c_o = '0;
    if (32'(rd_idx_i) < NUM_NONCES) begin
      rd_data_c_o = mem_q[rd_idx_i];
    end
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      if (wr_en_i[p] && (wr_idx_i[p] == rd_idx_i)) begin
        rd_data_c_o = wr_data_i[p];
      end
    end
  end

endmodule

// File: rtl/nonce_dispatcher.sv
// Round-based scheduler sharing NUM_CORES SHA cores across NUM_NONCES nonces,
// collecting H0 results and streaming them to memory once all are done.

module nonce_dispatcher
  import nonce_dispatch_pkg::*;
#(
  parameter int unsigned NUM_NONCES = 16,
  parameter int unsigned NUM_CORES  = 4
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                start,
  input  logic [ADDR_W-1:0]                   output_addr,
  output logic                                done,
  output logic [NUM_CORES-1:0]                core_start,
  output logic [NUM_CORES-1:0][NONCE_W-1:0]   core_nonce,
  input  logic [NUM_CORES-1:0]                core_done,
  input  logic [NUM_CORES-1:0][WORD_W-1:0]    core_h0,
  output logic                                mem_we,
  output logic [ADDR_W-1:0]                   mem_addr,
  output logic [WORD_W-1:0]                   mem_write_data
);

  localparam int unsigned IDX_W = idx_width(NUM_NONCES);

  dispatch_state_t state_q, state_d;
  logic [NONCE_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [NUM_CORES-1:0] pending_q, pending_d;

  logic                               done_d;
  logic [NUM_CORES-1:0]               core_start_d;
  logic [NUM_CORES-1:0][NONCE_W-1:0]  core_nonce_d;
  logic                               mem_we_d;
  logic [ADDR_W-1:0]                  mem_addr_d;
  logic [WORD_W-1:0]                  mem_write_data_d;

  logic [NUM_CORES-1:0]               capture_c;
  logic [NUM_CORES-1:0][IDX_W-1:0]    wr_idx_c;
  logic [IDX_W-1:0]                   rd_idx_c;
  logic [WORD_W-1:0]                  rd_data_c;

  // Only dones from cores still owed a result, and only while waiting, are kept.
  always_comb begin
    capture_c = '0;
    if (state_q == ST_WAIT) begin
      capture_c = core_done & pending_q;
    end
    for (int unsigned c = 0; c < NUM_CORES; c++) begin
      wr_idx_c[c] = IDX_W'(core_nonce[c]);
    end
  end

  // Word to present on the next write cycle: 0 on entry, else the one after idx_q.
  always_comb begin
    rd_idx_c = '0;
    if (state_q == ST_WRITE) begin
      rd_idx_c = idx_q + IDX_W'(1);
    end
  end

  nonce_result_buf #(
    .NUM_NONCES (NUM_NONCES),
    .NUM_PORTS  (NUM_CORES),
    .IDX_W      (IDX_W)
  ) u_result_buf (
    .clk         (clk),
    .wr_en_i     (capture_c),
    .wr_idx_i    (wr_idx_c),
    .wr_data_i   (core_h0),
    .rd_idx_i    (rd_idx_c),
    .rd_data_c_o (rd_data_c)
  );

  always_comb begin
    state_d          = state_q;
    base_d           = base_q;
    addr_d           = addr_q;
    idx_d            = idx_q;
    pending_d        = pending_q & ~capture_c;
    core_start_d     = '0;
    core_nonce_d     = core_nonce;
    mem_we_d         = 1'b0;
    mem_addr_d       = mem_addr;
    mem_write_data_d = mem_write_data;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          addr_d  = output_addr;
          base_d  = '0;
          state_d = ST_DISPATCH;
        end
      end
      ST_DISPATCH: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (pending_d == '0) begin
          if ((base_q + NONCE_W'(NUM_CORES)) < NONCE_W'(NUM_NONCES)) begin
            base_d  = base_q + NONCE_W'(NUM_CORES);
            state_d = ST_DISPATCH;
          end else begin
            idx_d   = '0;
            state_d = ST_WRITE;
          end
        end
      end
      ST_WRITE: begin
        if (idx_q == IDX_W'(NUM_NONCES - 1)) begin
          state_d = ST_IDLE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are registered, so the round's pulses are prepared on entry to DISPATCH.
    if (state_d == ST_DISPATCH) begin
      for (int unsigned c = 0; c < NUM_CORES; c++) begin
        if ((base_d + NONCE_W'(c)) < NONCE_W'(NUM_NONCES)) begin
          core_start_d[c] = 1'b1;
          core_nonce_d[c] = base_d + NONCE_W'(c);
          pending_d[c]    = 1'b1;
        end
      end
    end

    if (state_d == ST_WRITE) begin
      mem_we_d         = 1'b1;
      mem_addr_d       = addr_d + ADDR_W'(idx_d);
      mem_write_data_d = rd_data_c;
    end

    done_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      base_q         <= '0;
      addr_q         <= '0;
      idx_q          <= '0;
      pending_q      <= '0;
      done           <= 1'b1;
      core_start     <= '0;
      core_nonce     <= '0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_write_data <= '0;
    end else begin
      state_q        <= state_d;
      base_q         <= base_d;
      addr_q         <= addr_d;
      idx_q          <= idx_d;
      pending_q      <= pending_d;
      done           <= done_d;
      core_start     <= core_start_d;
      core_nonce     <= core_nonce_d;
      mem_we         <= mem_we_d;
      mem_addr       <= mem_addr_d;
      mem_write_data <= mem_write_data_d;
    end
  end

endmodule

// File: tb/tb_nonce_dispatcher.sv
// Scoreboard bench for nonce_dispatcher: a 16-nonce/4-core instance and a
// 6-nonce/4-core instance driven by latency-programmable core models.

module tb_nonce_dispatcher;

  typedef struct packed {
    logic [15:0] addr;
    logic [31:0] data;
  } wr_t;

  typedef struct packed {
    logic [3:0]       mask;
    logic [3:0][31:0] nonce;
  } disp_t;

  typedef struct packed {
    logic [15:0]     addr;
    logic [31:0]     h0base;
    logic [3:0][7:0] lat;
  } job_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   reset;
  logic [1:0]             start_v;
  logic [1:0][15:0]       oaddr_v;
  logic [1:0]             done_v;
  logic [1:0][3:0]        cstart_v;
  logic [1:0][3:0][31:0]  cnonce_v;
  logic [1:0][3:0]        rdone_v, inj_v, cdone_v;
  logic [1:0][3:0][31:0]  rh0_v, h0_v;
  logic [1:0]             mwe_v;
  logic [1:0][15:0]       maddr_v;
  logic [1:0][31:0]       mdata_v;

  int          tests, fails;
  int          lat_m [2][4];
  int          cnt_m [2][4];
  logic [31:0] nonce_m [2][4];
  logic [31:0] h0base_m [2];
  int          cyc;
  int          last_disp [2];
  int          exp_gap [2];
  wr_t         wr_q [2][$];
  disp_t       disp_q [2][$];
  job_t        jobs [4];
  job_t        job6;

  assign cdone_v = rdone_v | inj_v;
  always_comb begin
    for (int i = 0; i < 2; i++)
      for (int c = 0; c < 4; c++)
        h0_v[i][c] = inj_v[i][c] ? 32'hDEAD_BEEF : rh0_v[i][c];
  end

  nonce_dispatcher #(.NUM_NONCES(16), .NUM_CORES(4)) u_dut (
    .clk(clk), .reset(reset), .start(start_v[0]), .output_addr(oaddr_v[0]),
    .done(done_v[0]), .core_start(cstart_v[0]), .core_nonce(cnonce_v[0]),
    .core_done(cdone_v[0]), .core_h0(h0_v[0]), .mem_we(mwe_v[0]),
    .mem_addr(maddr_v[0]), .mem_write_data(mdata_v[0])
  );

  nonce_dispatcher #(.NUM_NONCES(6), .NUM_CORES(4)) u_dut6 (
    .clk(clk), .reset(reset), .start(start_v[1]), .output_addr(oaddr_v[1]),
    .done(done_v[1]), .core_start(cstart_v[1]), .core_nonce(cnonce_v[1]),
    .core_done(cdone_v[1]), .core_h0(h0_v[1]), .mem_we(mwe_v[1]),
    .mem_addr(maddr_v[1]), .mem_write_data(mdata_v[1])
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Core models: done pulses lat cycles after the start pulse, h0 = base + nonce.
  initial begin
    rdone_v = '0;
    rh0_v   = '0;
    for (int i = 0; i < 2; i++)
      for (int c = 0; c < 4; c++) begin
        cnt_m[i][c]   = 0;
        nonce_m[i][c] = '0;
      end
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
        for (int c = 0; c < 4; c++) begin
          rdone_v[i][c] = 1'b0;
          if (reset) begin
            cnt_m[i][c] = 0;
          end else begin
            if (cnt_m[i][c] > 0) begin
              cnt_m[i][c]--;
              if (cnt_m[i][c] == 0) begin
                rdone_v[i][c] = 1'b1;
                rh0_v[i][c]   = h0base_m[i] + nonce_m[i][c];
              end
            end
            if (cstart_v[i][c]) begin
              cnt_m[i][c]   = lat_m[i][c];
              nonce_m[i][c] = cnonce_v[i][c];
            end
          end
        end
      end
    end
  end

  // Output monitor: pops dispatch and write expectations as the DUTs produce them.
  initial begin
    disp_t d;
    wr_t   w;
    cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      for (int i = 0; i < 2; i++) begin
        if (cstart_v[i] != 4'b0000) begin
          if (last_disp[i] >= 0)
            check($sformatf("dispatch_gap[%0d]", i), 64'(cyc - last_disp[i]), 64'(exp_gap[i]));
          last_disp[i] = cyc;
          if (disp_q[i].size() == 0) begin
            check($sformatf("unexpected_dispatch[%0d]", i), 64'(cstart_v[i]), 64'd0);
          end else begin
            d = disp_q[i].pop_front();
            check($sformatf("dispatch_mask[%0d]", i), 64'(cstart_v[i]), 64'(d.mask));
            for (int c = 0; c < 4; c++)
              if (d.mask[c])
                check($sformatf("dispatch_nonce[%0d][%0d]", i, c), 64'(cnonce_v[i][c]), 64'(d.nonce[c]));
          end
        end
        if (mwe_v[i]) begin
          if (wr_q[i].size() == 0) begin
            check($sformatf("unexpected_write[%0d]", i), {16'h0, maddr_v[i], mdata_v[i]}, 64'd0);
          end else begin
            w = wr_q[i].pop_front();
            check($sformatf("wr_addr[%0d]", i), 64'(maddr_v[i]), 64'(w.addr));
            check($sformatf("wr_data[%0d]", i), 64'(mdata_v[i]), 64'(w.data));
          end
        end
      end
    end
  end

  task automatic do_reset(input int i);
    reset = 1'b1;
    @(negedge clk);
    check("rst_done", 64'(done_v[i]), 64'd1);
    check("rst_mem_we", 64'(mwe_v[i]), 64'd0);
    check("rst_core_start", 64'(cstart_v[i]), 64'd0);
    check("rst_mem_addr", 64'(maddr_v[i]), 64'd0);
    reset      = 1'b0;
    inj_v      = '0;
    start_v[i] = 1'b0;
    wr_q[i].delete();
    disp_q[i].delete();
    last_disp[i] = -1;
    @(negedge clk);
  endtask

  // mode 0: plain job; 1: spurious done + second start; 2: reset in WAIT; 3: reset in 3rd write.
  task automatic run_job(input int i, input int n, input job_t j, input int mode);
    int    maxl, rounds, low, nw;
    disp_t d;
    maxl = 0;
    for (int c = 0; c < 4; c++) begin
      lat_m[i][c] = int'(j.lat[c]);
      if (lat_m[i][c] > maxl) maxl = lat_m[i][c];
    end
    h0base_m[i]  = j.h0base;
    exp_gap[i]   = maxl + 1;
    last_disp[i] = -1;
    rounds       = (n + 3) / 4;
    for (int k = 0; k < n; k++)
      wr_q[i].push_back({16'(j.addr + 16'(k)), j.h0base + 32'(k)});
    for (int r = 0; r < rounds; r++) begin
      d = '0;
      for (int c = 0; c < 4; c++) begin
        if (r * 4 + c < n) begin
          d.mask[c]  = 1'b1;
          d.nonce[c] = 32'(r * 4 + c);
        end
      end
      disp_q[i].push_back(d);
    end
    start_v[i] = 1'b1;
    oaddr_v[i] = j.addr;
    @(negedge clk);
    start_v[i] = 1'b0;
    low = 0;
    nw  = 0;
    while (done_v[i] == 1'b0 && low < 3000) begin
      low++;
      if (mwe_v[i]) nw++;
      if (mode == 1) begin
        if (low == 3) begin
          start_v[i] = 1'b1;
          oaddr_v[i] = 16'hBEEF;
        end
        if (low == 4) start_v[i] = 1'b0;
        inj_v[i] = (mwe_v[i] && nw <= 2) ? 4'b0100 : 4'b0000;
      end
      if (mode == 2 && low == 2) begin
        do_reset(i);
        return;
      end
      if (mode == 3 && mwe_v[i] && nw == 3) begin
        do_reset(i);
        return;
      end
      @(negedge clk);
    end
    inj_v[i] = '0;
    check("job_latency", 64'(low), 64'(rounds * (maxl + 1) + n));
    check("write_count", 64'(nw), 64'(n));
    check("writes_drained", 64'(wr_q[i].size()), 64'd0);
    check("dispatch_drained", 64'(disp_q[i].size()), 64'd0);
    check("done_after_job", 64'(done_v[i]), 64'd1);
    @(negedge clk);
  endtask

  initial begin
    tests   = 0;
    fails   = 0;
    reset   = 1'b1;
    start_v = '0;
    oaddr_v = '0;
    inj_v   = '0;
    for (int i = 0; i < 2; i++) begin
      last_disp[i] = -1;
      exp_gap[i]   = 0;
      h0base_m[i]  = '0;
      for (int c = 0; c < 4; c++) lat_m[i][c] = 1;
    end

    jobs[0] = '{addr: 16'h0100, h0base: 32'hA000_0000, lat: {8'd3, 8'd3, 8'd3, 8'd3}};
    jobs[1] = '{addr: 16'hFFFE, h0base: 32'h5A5A_0000, lat: {8'd1, 8'd1, 8'd1, 8'd1}};
    jobs[2] = '{addr: 16'h2000, h0base: 32'h00C0_FF00, lat: {8'd2, 8'd9, 8'd9, 8'd9}};
    jobs[3] = '{addr: 16'h7FF0, h0base: 32'h1234_0000, lat: {8'd7, 8'd2, 8'd4, 8'd1}};
    job6    = '{addr: 16'h0040, h0base: 32'hB000_0000, lat: {8'd2, 8'd2, 8'd2, 8'd2}};

    repeat (3) @(negedge clk);
    check("reset_done", 64'(done_v[0]), 64'd1);
    check("reset_mem_we", 64'(mwe_v[0]), 64'd0);
    check("reset_core_start", 64'(cstart_v[0]), 64'd0);
    check("reset_core_nonce", 64'(cnonce_v[0][3]), 64'd0);
    check("reset_mem_data", 64'(mdata_v[0]), 64'd0);
    check("reset_done6", 64'(done_v[1]), 64'd1);
    reset = 1'b0;
    @(negedge clk);

    for (int k = 0; k < 4; k++) run_job(0, 16, jobs[k], 0);
    run_job(1, 6, job6, 0);
    run_job(0, 16, jobs[0], 1);
    run_job(0, 16, jobs[2], 2);
    run_job(0, 16, jobs[0], 3);
    run_job(0, 16, jobs[3], 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (tests %0d, failed %0d)", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/nonce_dispatcher.md
# nonce_dispatcher

Round-based scheduler that shares `NUM_CORES` second-stage SHA-256 cores among `NUM_NONCES` nonces for the bitcoin hash flow. It pulses each core's start with an assigned nonce and collects each core's H0 result into a nonce-indexed buffer. Once every nonce has completed, it writes the buffer to memory at `output_addr`. It sits between the top-level bitcoin hash FSM, which has already computed the first-block midstate, and the memory write port.

## Interface
- `NUM_NONCES`, 16, total nonces to evaluate (nonces 0..NUM_NONCES-1), ≥1
- `NUM_CORES`, 4, number of SHA cores driven, 1..NUM_NONCES
- `clk` in 1: the single clock; all logic on its rising edge
- `reset` in 1: synchronous, active-high
- `start` in 1: begin a job; sampled only in IDLE
- `output_addr` in 16: base word address for results; captured when `start` is accepted
- `done` out 1: high exactly while in IDLE
- `core_start` out NUM_CORES: one-cycle start pulse per core
- `core_nonce` out NUM_CORES×32: nonce for each core; held stable from pulse until that core's done
- `core_done` in NUM_CORES: one-cycle completion pulse per core
- `core_h0` in NUM_CORES×32: H0 result per core; valid in the `core_done` cycle
- `mem_we` out 1: memory write enable
- `mem_addr` out 16: memory word address
- `mem_write_data` out 32: memory write data

## Operation
- States: IDLE, DISPATCH, WAIT, WRITE.
- Reset forces the following, regardless of current state (including mid-job or mid-write):
  - state = IDLE, `done` = 1
  - `core_start` = 0, `core_nonce` = 0, pending = 0
  - `mem_we` = 0, `mem_addr` = 0, `mem_write_data` = 0
  - base nonce = 0, write index = 0
  - the result buffer is not cleared.
- IDLE
  - `start` = 1 → capture `output_addr`, set base = 0, go to DISPATCH.
  - `start` is ignored in every other state.
- DISPATCH (one cycle)
  - For each core c with base+c < NUM_NONCES:
    - `core_start[c]` = 1 and `core_nonce[c]` = base+c
    - set pending[c].
  - Cores with base+c ≥ NUM_NONCES are not started; this happens in the last round when NUM_NONCES is not a multiple of NUM_CORES.
  - Go to WAIT.
- WAIT
  - On `core_done[c]` with pending[c] set: write `core_h0[c]` into result[`core_nonce[c]`] and clear pending[c].
  - `core_done` from a non-pending core is ignored: no write, no state effect.
  - Simultaneous dones from several cores are all captured in the same cycle.
  - When every pending bit is cleared, counting dones in the current cycle:
    - if base+NUM_CORES < NUM_NONCES: base += NUM_CORES, go to DISPATCH
    - otherwise: index = 0, go to WRITE.
- WRITE
  - One word per cycle: `mem_we` = 1, `mem_addr` = captured base + index (mod 2^16, wraps), `mem_write_data` = result[index].
  - After index NUM_NONCES-1: go to IDLE with `mem_we` = 0.
- Arithmetic
  - Nonce and base counters are 32-bit and never overflow within parameter range.
  - Address addition is 16-bit truncating.

## Timing
- All outputs are registered.
- `start` is sampled at edge N; the DISPATCH cycle (`core_start` high) is N+1.
- `core_start` is exactly one cycle wide per round.
- A `core_done` is ignored in the DISPATCH cycle itself; the earliest accepted done is the first WAIT cycle.
- The final done of a round is captured at edge M; the next DISPATCH cycle (or first WRITE cycle) is M+1.
- The WRITE phase lasts exactly NUM_NONCES cycles; `done` rises the cycle after the last write.
- Total job latency = 1 + Σ over rounds of (1 + WAIT cycles) + NUM_NONCES cycles.

## Structure
- Shared package `nonce_dispatch_pkg` holds:
  - the state enum (`dispatch_state_t`)
  - width constants `NONCE_W` = 32, `ADDR_W` = 16, `WORD_W` = 32.
- Sub-module `nonce_result_buf`:
  - NUM_NONCES×32 storage with up to NUM_CORES write ports (index, data, enable)
  - one combinational read port indexed by the write index.
- Pending-bit vector and round control stay in the top level.

## Test plan
- Default params, each core returns `core_h0` = 32'hA000_0000 + nonce after 3 cycles:
  - 4 rounds of 4 `core_start` pulses with nonces 0..15
  - then 16 writes to 0x0100..0x010F with data 0xA0000000..0xA000000F
  - then `done` = 1.
- NUM_NONCES=6, NUM_CORES=4:
  - round 2 pulses only cores 0–1 with nonces 4–5; cores 2–3 see no pulse
  - exactly 6 writes occur.
- Staggered dones:
  - core 3 done at cycle 2, cores 0–2 simultaneously at cycle 9
  - all four results are captured; next DISPATCH occurs at cycle 10 and not earlier.
- Spurious `core_done[2]` during WRITE and a second `start` mid-job: no buffer corruption, no restart, write sequence unchanged.
- `output_addr` = 0xFFFE, NUM_NONCES=4: writes go to 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- `reset` asserted in WAIT and again in the 3rd WRITE cycle:
  - the next cycle shows IDLE, `done` = 1, `mem_we` = 0, `core_start` = 0
  - a fresh `start` then completes a full correct job.
